// File: rtl/mult_share_arb.sv
// mult_share_arb: NREQ requesters share a single 3x3 unsigned multiplier.
// Round-robin arbitration feeds one registered result slot. The slot is
// drained by a valid/ready consumer.
// Optional feature, guarded by macro MULT_ZERO_SKIP_EN:
//   - A granted pair with a zero magnitude is acknowledged but dropped.
//   - The 8-bit saturating counter skip_cnt counts these dropped pairs.
//
// Handshake rules:
//   - req is held by its requester until the matching gnt pulse. That
//     pulse is combinational and lasts one cycle.
//   - A product transfers on any rising edge where out_valid and
//     out_ready are both high.
//   - While out_valid is high and out_ready is low, the slot holds its
//     contents.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [6:0]        out_prod
`ifdef MULT_ZERO_SKIP_EN
  ,
  output logic [7:0]        skip_cnt
`endif
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] cand;
  logic            sel_found;
  logic            res_free;
  logic            grant;
  logic [3:0]      a_sel;
  logic [3:0]      b_sel;
  logic [5:0]      mag_prod;
  logic            neg;
  logic [6:0]      prod_val;
`ifdef MULT_ZERO_SKIP_EN
  logic            zero_op;
`endif

  // Round-robin pick: first asserted request at or after rr_ptr, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Grant when the slot is free; a product leaving this cycle frees it.
  // Reset suppresses the grant immediately.
  always_comb begin
    res_free = !out_valid || out_ready;
    grant    = sel_found && res_free && !rst;
    gnt      = grant ? (NREQ'(1) << sel_id) : '0;
  end

  // Single shared multiplier fed by the selected requester's operands.
  // Negating a zero magnitude yields zero, so -0 operands need no special case.
  always_comb begin
    a_sel    = a_in[{sel_id, 2'b00} +: 4];
    b_sel    = b_in[{sel_id, 2'b00} +: 4];
    mag_prod = 6'(a_sel[2:0]) * 6'(b_sel[2:0]);
    neg      = a_sel[3] ^ b_sel[3];
    prod_val = neg ? (7'd0 - {1'b0, mag_prod}) : {1'b0, mag_prod};
`ifdef MULT_ZERO_SKIP_EN
    zero_op  = (a_sel[2:0] == 3'd0) || (b_sel[2:0] == 3'd0);
`endif
  end

  // Result slot and arbitration pointer.
  // A grant reloads the slot with no bubble; a handshake alone empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
`ifdef MULT_ZERO_SKIP_EN
      skip_cnt  <= '0;
`endif
    end else begin
      if (grant) begin
        rr_ptr <= ID_W'((int'(sel_id) + 1) % NREQ);
      end
`ifdef MULT_ZERO_SKIP_EN
      if (grant && zero_op) begin
        if (skip_cnt != 8'hFF) begin
          skip_cnt <= skip_cnt + 8'd1;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end else
`endif
      if (grant) begin
        out_valid <= 1'b1;
        out_prod  <= prod_val;
        out_id    <= sel_id;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb.
// The reference model is a scoreboard queue of {id, product} entries.
// The grant rule comes from the round-robin definition.
// Products come from signed integer arithmetic on the decoded operands.
// Define MULT_ZERO_SKIP_EN when building to exercise the skip variant.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] a_in = '0;
  logic [4*NREQ-1:0] b_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ID_W-1:0]   out_id;
  logic [6:0]        out_prod;
`ifdef MULT_ZERO_SKIP_EN
  logic [7:0]        skip_cnt;
`endif

  mult_share_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .a_in(a_in),
    .b_in(b_in),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id(out_id),
    .out_prod(out_prod)
`ifdef MULT_ZERO_SKIP_EN
    ,
    .skip_cnt(skip_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard and model state
  logic [8:0] exp_q[$];
  int m_ptr = 0;
  int m_skip = 0;
  int checks = 0;
  int failures = 0;
  logic [NREQ-1:0] obs_gnt;
  int last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected {id, product} for requester i from signed arithmetic.
  function automatic logic [8:0] model_item(input int i);
    logic [3:0] a;
    logic [3:0] b;
    int p;
    a = a_in[4*i +: 4];
    b = b_in[4*i +: 4];
    p = int'(a[2:0]) * int'(b[2:0]);
    if (a[3] != b[3]) p = -p;
    return {ID_W'(i), p[6:0]};
  endfunction

  function automatic bit model_zero(input int i);
    logic [3:0] a;
    logic [3:0] b;
    a = a_in[4*i +: 4];
    b = b_in[4*i +: 4];
    return (a[2:0] == 3'd0) || (b[2:0] == 3'd0);
  endfunction

  // One clock cycle.
  // At the falling edge: check gnt and outputs against the model.
  // At the rising edge: advance the model.
  task automatic tick();
    int g;
    bit free;
    bit hs;
    @(negedge clk);
    free = (exp_q.size() == 0) || out_ready;
    g = -1;
    if (free) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    obs_gnt = gnt;
    chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("result", 32'({out_id, out_prod}), 32'(exp_q[0]));
`ifdef MULT_ZERO_SKIP_EN
    chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
`endif
    hs = (exp_q.size() != 0) && out_ready;
    last_g = g;
    @(posedge clk);
    if (hs) void'(exp_q.pop_front());
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
`ifdef MULT_ZERO_SKIP_EN
      if (model_zero(g)) begin
        if (m_skip < 255) m_skip++;
      end else exp_q.push_back(model_item(g));
`else
      exp_q.push_back(model_item(g));
`endif
    end
    #1;
  endtask

  // Asynchronous reset pulse, released away from the clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(out_prod), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    m_skip = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    // +3 * -5 from requester 0
    req = 4'b0001;
    a_in[3:0] = 4'b0011;
    b_in[3:0] = 4'b1101;
    out_ready = 1'b1;
    tick();
    chk("r27_gnt", 32'(obs_gnt), 32'd1);
    req = 4'b0000;
    chk("r27_valid", 32'(out_valid), 32'd1);
    chk("r27_id", 32'(out_id), 32'd0);
    chk("r27_prod", 32'(out_prod), 32'(7'b1110001));
    tick();

    // All requesters held: rotation 0,1,2,3,0 at full rate
    do_reset();
    a_in = 16'h3A57;
    b_in = 16'hC26F;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r28_gnt", 32'(obs_gnt), 32'd1 << (k % NREQ));
      chk("r28_valid", 32'(out_valid), 32'd1);
    end
    req = 4'b0000;
    tick();

    // Backpressure: no grant while the slot is full and unread
    do_reset();
    out_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0100;
    a_in[11:8] = 4'b1110;
    b_in[11:8] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r29_stall_gnt", 32'(obs_gnt), 32'd0);
      chk("r29_hold_id", 32'(out_id), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("r29_gnt", 32'(obs_gnt), 32'd4);
    req = 4'b0000;
    chk("r29_id", 32'(out_id), 32'd2);
    chk("r29_prod", 32'(out_prod), 32'(7'b1110100));
    tick();

    // Reset with a pending product and rr_ptr at 2
    do_reset();
    out_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk("r31_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    req = 4'b0101;
    out_ready = 1'b1;
    tick();
    chk("r31_first_gnt", 32'(obs_gnt), 32'd1);
    req = 4'b0100;
    tick();
    chk("r31_second_gnt", 32'(obs_gnt), 32'd4);
    req = 4'b0000;
    tick();

    // -0 operand
    do_reset();
    req = 4'b0001;
    a_in[3:0] = 4'b1000;
    b_in[3:0] = 4'b0111;
    out_ready = 1'b1;
    tick();
    chk("r30_gnt", 32'(obs_gnt), 32'd1);
    req = 4'b0000;
`ifdef MULT_ZERO_SKIP_EN
    chk("r30_valid", 32'(out_valid), 32'd0);
    chk("r30_skip", 32'(skip_cnt), 32'd1);
`else
    chk("r30_valid", 32'(out_valid), 32'd1);
    chk("r30_prod", 32'(out_prod), 32'd0);
`endif
    tick();

    // Random traffic: requesters hold req and operands until granted
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          a_in[4*i +: 4] = 4'($urandom_range(0, 15));
          b_in[4*i +: 4] = 4'($urandom_range(0, 15));
        end
      end
      tick();
      if (last_g >= 0) req[last_g] = 1'b0;
    end

    // Drain remaining work
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (last_g >= 0) req[last_g] = 1'b0;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
